seg7_accum_display: RTL and testbench

//  Parametrised successor to the board-level switch/adder/seven-segment top.

---
 rtl/seg7_accum_display.sv | 146 ++++++++++++++
 tb/tb_seg7_accum_display.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_accum_display.sv
// seg7_accum_display: debounced add/clear keys drive a registered accumulator.
// The accumulator is shown in hex on NUM_DIGITS active-low seven-segment digits,
// and the digit-0 decimal point lights when carry is set.
// Optional build macro: SEG7_LEADING_BLANK_EN, which blanks leading zero digits
// above digit 0.
module seg7_accum_display #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned NUM_DIGITS   = 2,
    parameter int unsigned DEBOUNCE_CYC = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       operand,
    input  logic                    add_key_n,
    input  logic                    clr_key_n,
    output logic [8*NUM_DIGITS-1:0] hex,
    output logic [DATA_W-1:0]       acc,
    output logic                    carry
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam int unsigned PAD_W = 4 * NUM_DIGITS;
    localparam int unsigned HEX_W = 8 * NUM_DIGITS;
`ifdef SEG7_LEADING_BLANK_EN
    localparam logic [HEX_W-1:0] HEX_RST = {NUM_DIGITS{8'hFF}} & ~HEX_W'(8'h3F);
`else
    localparam logic [HEX_W-1:0] HEX_RST = {NUM_DIGITS{8'hC0}};
`endif

    // Key index 0 = add, 1 = clear.
    logic [1:0]       key_n;
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       level_q;
    logic [1:0]       armed_q;
    logic [1:0]       pulse_q;
    logic [CNT_W-1:0] cnt_q [2];

    logic [DATA_W:0]  sum;
    logic [PAD_W-1:0] acc_pad;
    logic [HEX_W-1:0] hex_d;
`ifdef SEG7_LEADING_BLANK_EN
    logic             seen_nz;
`endif

    assign key_n   = {clr_key_n, add_key_n};
    assign sum     = {1'b0, acc} + {1'b0, operand};
    assign acc_pad = PAD_W'(acc);

    // Active-low hex glyph, dp bit off.
    function automatic logic [7:0] glyph(input logic [3:0] nib);
        case (nib)
            4'h0: glyph = 8'hC0;
            4'h1: glyph = 8'hF9;
            4'h2: glyph = 8'hA4;
            4'h3: glyph = 8'hB0;
            4'h4: glyph = 8'h99;
            4'h5: glyph = 8'h92;
            4'h6: glyph = 8'h82;
            4'h7: glyph = 8'hF8;
            4'h8: glyph = 8'h80;
            4'h9: glyph = 8'h90;
            4'hA: glyph = 8'h88;
            4'hB: glyph = 8'h83;
            4'hC: glyph = 8'hC6;
            4'hD: glyph = 8'hA1;
            4'hE: glyph = 8'h86;
            default: glyph = 8'h8E;
        endcase
    endfunction

    // Synchronise and debounce both keys; emit one pulse per accepted press.
    // Sync flops reset to "pressed" and a key is armed only after a release is
    // seen, so a key held through reset cannot produce a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            level_q  <= '1;
            armed_q  <= '0;
            pulse_q  <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            for (int k = 0; k < 2; k++) begin
                pulse_q[k] <= 1'b0;
                if (sync2_q[k]) begin
                    armed_q[k] <= 1'b1;
                end
                if (sync2_q[k] == level_q[k]) begin
                    cnt_q[k] <= '0;
                end else if (cnt_q[k] == CNT_LAST) begin
                    cnt_q[k]   <= '0;
                    level_q[k] <= sync2_q[k];
                    pulse_q[k] <= ~sync2_q[k] & armed_q[k];
                end else begin
                    cnt_q[k] <= cnt_q[k] + 1'b1;
                end
            end
        end
    end

    // Accumulate on add pulses; clear takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            carry <= 1'b0;
        end else if (pulse_q[1]) begin
            acc   <= '0;
            carry <= 1'b0;
        end else if (pulse_q[0]) begin
            {carry, acc} <= sum;
        end
    end

    // Build per-digit glyphs, scanning from the top digit down for blanking.
    always_comb begin
        hex_d = '1;
`ifdef SEG7_LEADING_BLANK_EN
        seen_nz = 1'b0;
`endif
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            hex_d[8*i +: 8] = glyph(acc_pad[4*i +: 4]);
`ifdef SEG7_LEADING_BLANK_EN
            seen_nz = seen_nz | (acc_pad[4*i +: 4] != 4'h0);
            if (i > 0 && !seen_nz) begin
                hex_d[8*i +: 8] = 8'hFF;
            end
`endif
        end
        hex_d[7] = ~carry;
    end

    // Register the display one cycle behind the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex <= HEX_RST;
        end else begin
            hex <= hex_d;
        end
    end

endmodule

// File: tb/tb_seg7_accum_display.sv
// Directed bench for seg7_accum_display: an 8-bit/2-digit instance and a
// 12-bit/4-digit instance, each with its own keys and reset.
module tb_seg7_accum_display;

    localparam int unsigned DEB = 16;

`ifdef SEG7_LEADING_BLANK_EN
    localparam logic [15:0] HEX8_ZERO  = 16'hFFC0;
    localparam logic [15:0] HEX8_CARRY = 16'hFF40;
    localparam logic [31:0] HEX12_ZERO = 32'hFFFF_FFC0;
    localparam logic [31:0] HEX12_ABC  = 32'hFF_88_83_C6;
`else
    localparam logic [15:0] HEX8_ZERO  = 16'hC0C0;
    localparam logic [15:0] HEX8_CARRY = 16'hC040;
    localparam logic [31:0] HEX12_ZERO = 32'hC0C0_C0C0;
    // digit3=0, digit2=A, digit1=b, digit0=C
    localparam logic [31:0] HEX12_ABC  = 32'hC0_88_83_C6;
`endif

    logic        clk = 1'b0;
    logic        rst8_n;
    logic        rst12_n;
    logic [7:0]  operand8;
    logic [11:0] operand12;
    logic        add8_n;
    logic        clr8_n;
    logic        add12_n;
    logic        clr12_n;
    logic [15:0] hex8;
    logic [31:0] hex12;
    logic [7:0]  acc8;
    logic [11:0] acc12;
    logic        carry8;
    logic        carry12;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seg7_accum_display #(
        .DATA_W      (8),
        .NUM_DIGITS  (2),
        .DEBOUNCE_CYC(DEB)
    ) dut8 (
        .clk      (clk),
        .rst_n    (rst8_n),
        .operand  (operand8),
        .add_key_n(add8_n),
        .clr_key_n(clr8_n),
        .hex      (hex8),
        .acc      (acc8),
        .carry    (carry8)
    );

    seg7_accum_display #(
        .DATA_W      (12),
        .NUM_DIGITS  (4),
        .DEBOUNCE_CYC(DEB)
    ) dut12 (
        .clk      (clk),
        .rst_n    (rst12_n),
        .operand  (operand12),
        .add_key_n(add12_n),
        .clr_key_n(clr12_n),
        .hex      (hex12),
        .acc      (acc12),
        .carry    (carry12)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // key: 0 = add8, 1 = clr8, 2 = add12
    task automatic set_key(input int key, input logic v);
        case (key)
            0: add8_n = v;
            1: clr8_n = v;
            default: add12_n = v;
        endcase
    endtask

    task automatic press(input int key, input int hold);
        set_key(key, 1'b0);
        tick(hold);
        set_key(key, 1'b1);
        tick(DEB + 6);
    endtask

    initial begin
        rst8_n    = 1'b0;
        rst12_n   = 1'b0;
        operand8  = 8'h00;
        operand12 = 12'h000;
        add8_n    = 1'b1;
        clr8_n    = 1'b1;
        add12_n   = 1'b1;
        clr12_n   = 1'b1;
        tick(3);

        // 1. reset state
        check("rst_acc", acc8, 8'h00);
        check("rst_carry", carry8, 1'b0);
        check("rst_hex", hex8, HEX8_ZERO);
        check("rst_hex12", hex12, HEX12_ZERO);
        rst8_n  = 1'b1;
        rst12_n = 1'b1;
        tick(5);
        check("post_rst_hex", hex8, HEX8_ZERO);

        // 2. clean press: pulse closes D+3 edges after the key is driven
        operand8 = 8'h3A;
        set_key(0, 1'b0);
        tick(DEB + 2);
        check("t2_acc_early", acc8, 8'h00);
        tick(1);
        check("t2_acc", acc8, 8'h3A);
        check("t2_hex_lag", hex8, HEX8_ZERO);
        tick(1);
        check("t2_hex", hex8, 16'hB088);
        tick(30);
        check("t2_held_once", acc8, 8'h3A);
        set_key(0, 1'b1);
        tick(DEB + 6);
        check("t2_release", acc8, 8'h3A);

        // 3. wrap with carry
        operand8 = 8'hC5;
        press(0, DEB + 8);
        check("t3_ff_acc", acc8, 8'hFF);
        check("t3_ff_hex", hex8, 16'h8E8E);
        operand8 = 8'h01;
        press(0, DEB + 8);
        check("t3_wrap_acc", acc8, 8'h00);
        check("t3_wrap_carry", carry8, 1'b1);
        check("t3_wrap_hex", hex8, HEX8_CARRY);
        press(1, DEB + 8);
        check("clr_acc", acc8, 8'h00);
        check("clr_carry", carry8, 1'b0);
        check("clr_hex", hex8, HEX8_ZERO);

        // 4. bounce in, long hold, bounce out: exactly one add
        operand8 = 8'h11;
        for (int b = 0; b < 3; b++) begin
            add8_n = 1'b0;
            tick(DEB / 2);
            add8_n = 1'b1;
            tick(DEB / 2);
        end
        check("t4_bounce_none", acc8, 8'h00);
        add8_n = 1'b0;
        tick(10 * DEB);
        check("t4_held_one", acc8, 8'h11);
        for (int b = 0; b < 3; b++) begin
            add8_n = 1'b1;
            tick(DEB / 2);
            add8_n = 1'b0;
            tick(DEB / 2);
        end
        add8_n = 1'b1;
        tick(DEB + 6);
        check("t4_release", acc8, 8'h11);

        // 5. simultaneous add and clear with acc=55
        operand8 = 8'h44;
        press(0, DEB + 8);
        check("t5_pre", acc8, 8'h55);
        add8_n = 1'b0;
        clr8_n = 1'b0;
        tick(DEB + 8);
        add8_n = 1'b1;
        clr8_n = 1'b1;
        tick(DEB + 6);
        check("t5_acc", acc8, 8'h00);
        check("t5_carry", carry8, 1'b0);

        // 6. reset mid-debounce with key held
        operand8 = 8'h22;
        press(0, DEB + 8);
        check("t6_pre", acc8, 8'h22);
        set_key(0, 1'b0);
        tick(8);
        rst8_n = 1'b0;
        #1;
        check("t6_rst_acc", acc8, 8'h00);
        check("t6_rst_hex", hex8, HEX8_ZERO);
        tick(1);
        rst8_n = 1'b1;
        tick(3 * DEB);
        check("t6_held_no_add", acc8, 8'h00);
        set_key(0, 1'b1);
        tick(DEB + 6);
        check("t6_release", acc8, 8'h00);
        press(0, DEB + 8);
        check("t6_repress", acc8, 8'h22);
        check("t6_hex", hex8, 16'hA4A4);

        // 6b. same sequence on the 12-bit, 4-digit instance
        operand12 = 12'hABC;
        set_key(2, 1'b0);
        tick(8);
        rst12_n = 1'b0;
        tick(1);
        rst12_n = 1'b1;
        tick(3 * DEB);
        check("t6w_held_no_add", acc12, 12'h000);
        check("t6w_hex_zero", hex12, HEX12_ZERO);
        set_key(2, 1'b1);
        tick(DEB + 6);
        press(2, DEB + 8);
        check("t6w_acc", acc12, 12'hABC);
        check("t6w_carry", carry12, 1'b0);
        check("t6w_hex", hex12, HEX12_ABC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
